// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: operand timing encodings, multiply/divide
// latencies, and the md-class opcode/funct values decode uses for D_is_md.
package pipeline_pkg;

  // Width of the Tuse/Tnew fields carried down the pipeline.
  localparam int T_W = 2;

  // A Tuse of all ones marks an operand the instruction does not read.
  localparam logic [T_W-1:0] TUSE_NONE = 2'b11;

  // Default busy windows of the multiply/divide unit.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // All md-class instructions are R-type and live under SPECIAL.
  localparam logic [5:0] OP_SPECIAL = 6'h00;

  typedef enum logic [5:0] {
    FUNCT_MFHI  = 6'h10,
    FUNCT_MTHI  = 6'h11,
    FUNCT_MFLO  = 6'h12,
    FUNCT_MTLO  = 6'h13,
    FUNCT_MULT  = 6'h18,
    FUNCT_MULTU = 6'h19,
    FUNCT_DIV   = 6'h1a,
    FUNCT_DIVU  = 6'h1b
  } md_funct_e;

  // True for any instruction that touches HI/LO or starts the md unit.
  function automatic logic is_md_class(input logic [5:0] opcode,
                                       input logic [5:0] funct);
    logic hit;
    hit = 1'b0;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the occupancy window of the multiply/divide unit. A start loads the
// full latency; the counter then drains one per cycle. A start during an
// active window reloads rather than accumulating.
module md_busy_tracker #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load on start, otherwise drain toward zero.
  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; synchronous reset aborts any window in progress.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // While reset is high the stale count is ignored; only a live start shows.
  assign md_busy = md_start || (!reset && (cnt_q != '0));

endmodule

// File: rtl/stall_controller.sv
// Hazard and stall sequencer for the five-stage pipeline. Compares D-stage
// source operands against in-flight E/M destinations using Tuse/Tnew, adds
// the multiply/divide busy hazard, and freezes PC/IF-ID while injecting a
// bubble into E. Also keeps a saturating stalled-cycle counter.
module stall_controller
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_dst,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        pc_en,
  output logic        D_reg_en,
  output logic        E_nop_n,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic        hz_rs;
  logic        hz_rt;
  logic        hz_md;
  logic        stall;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // An operand hazards when it is read sooner than a matching producer can forward it.
  function automatic logic src_hazard(input logic [4:0]     src,
                                      input logic [T_W-1:0] tuse,
                                      input logic [4:0]     e_dst,
                                      input logic [T_W-1:0] e_tnew,
                                      input logic [4:0]     m_dst,
                                      input logic [T_W-1:0] m_tnew);
    return (tuse != TUSE_NONE) && (src != 5'd0) &&
           (((src == e_dst) && (tuse < e_tnew)) ||
            ((src == m_dst) && (tuse < m_tnew)));
  endfunction

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .md_start  (E_md_start),
    .md_is_div (E_md_is_div),
    .md_busy   (md_busy)
  );

  // Same-cycle hazard detection; reset suppresses any stall.
  always_comb begin
    hz_rs = src_hazard(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew);
    hz_rt = src_hazard(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
    hz_md = D_is_md && md_busy;
    stall = !reset && (hz_rs || hz_rt || hz_md);
  end

  assign pc_en    = !stall;
  assign D_reg_en = !stall;
  assign E_nop_n  = !stall;

  // Next stalled-cycle count, saturating at all ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Performance counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench for stall_controller: directed vector table, md window
// and reset sequences, counter saturation, and a randomized run against a
// behavioural model.
module tb_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_dst, M_dst;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_is_div;
  logic        pc_en, D_reg_en, E_nop_n, md_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Model state: remaining busy cycles and total stalled cycles.
  int     m_busy_left = 0;
  longint m_stalls    = 0;

  always #5 clk = ~clk;

  stall_controller dut (
    .clk          (clk),
    .reset        (reset),
    .D_rs         (D_rs),
    .D_rt         (D_rt),
    .D_tuse_rs    (D_tuse_rs),
    .D_tuse_rt    (D_tuse_rt),
    .D_is_md      (D_is_md),
    .E_dst        (E_dst),
    .M_dst        (M_dst),
    .E_tnew       (E_tnew),
    .M_tnew       (M_tnew),
    .E_md_start   (E_md_start),
    .E_md_is_div  (E_md_is_div),
    .pc_en        (pc_en),
    .D_reg_en     (D_reg_en),
    .E_nop_n      (E_nop_n),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_src_hz(int src, int tuse, int edst, int etnew, int mdst, int mtnew);
    if (tuse == 3 || src == 0) return 1'b0;
    return (src == edst && tuse < etnew) || (src == mdst && tuse < mtnew);
  endfunction

  function automatic bit model_md_busy();
    return E_md_start || (!reset && m_busy_left > 0);
  endfunction

  function automatic bit model_stall();
    bit hz;
    hz = model_src_hz(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew) ||
         model_src_hz(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew) ||
         (D_is_md && model_md_busy());
    return !reset && hz;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit st;
    st = model_stall();
    if (reset) begin
      m_busy_left = 0;
      m_stalls    = 0;
    end else begin
      if (E_md_start)            m_busy_left = E_md_is_div ? 10 : 5;
      else if (m_busy_left > 0)  m_busy_left--;
      if (st && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_is_md = 1'b0; E_dst = 5'd0; M_dst = 5'd0; E_tnew = 2'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  // Cross one clock edge: update model, then settle past the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall_outs(input string name, input bit exp_stall);
    check({name, ".pc_en"},    pc_en,    !exp_stall);
    check({name, ".D_reg_en"}, D_reg_en, !exp_stall);
    check({name, ".E_nop_n"},  E_nop_n,  !exp_stall);
  endtask

  vec_t vecs[$];

  initial begin
    // rs tuse_rs rt tuse_rt is_md e_dst e_tnew m_dst m_tnew exp
    vecs.push_back('{rs:5, tuse_rs:0, rt:0, tuse_rt:3, is_md:0, e_dst:5, e_tnew:1, m_dst:0, m_tnew:0, exp_stall:1});
    vecs.push_back('{rs:0, tuse_rs:0, rt:0, tuse_rt:3, is_md:0, e_dst:0, e_tnew:1, m_dst:0, m_tnew:0, exp_stall:0});
    vecs.push_back('{rs:0, tuse_rs:3, rt:7, tuse_rt:1, is_md:0, e_dst:0, e_tnew:0, m_dst:7, m_tnew:1, exp_stall:0});
    vecs.push_back('{rs:0, tuse_rs:3, rt:7, tuse_rt:1, is_md:0, e_dst:0, e_tnew:0, m_dst:7, m_tnew:2, exp_stall:1});
    vecs.push_back('{rs:0, tuse_rs:3, rt:7, tuse_rt:3, is_md:0, e_dst:0, e_tnew:0, m_dst:7, m_tnew:2, exp_stall:0});
    vecs.push_back('{rs:9, tuse_rs:2, rt:0, tuse_rt:3, is_md:0, e_dst:9, e_tnew:2, m_dst:0, m_tnew:0, exp_stall:0});
    vecs.push_back('{rs:9, tuse_rs:1, rt:0, tuse_rt:3, is_md:0, e_dst:0, e_tnew:0, m_dst:9, m_tnew:2, exp_stall:1});
    vecs.push_back('{rs:4, tuse_rs:0, rt:0, tuse_rt:3, is_md:0, e_dst:3, e_tnew:2, m_dst:0, m_tnew:0, exp_stall:0});
    vecs.push_back('{rs:0, tuse_rs:3, rt:0, tuse_rt:3, is_md:1, e_dst:0, e_tnew:0, m_dst:0, m_tnew:0, exp_stall:0});
    vecs.push_back('{rs:0, tuse_rs:0, rt:0, tuse_rt:0, is_md:0, e_dst:0, e_tnew:2, m_dst:0, m_tnew:2, exp_stall:0});

    // Reset with a live hazard present: stall must be suppressed.
    idle_inputs();
    reset = 1'b1; D_rs = 5'd5; D_tuse_rs = 2'd0; E_dst = 5'd5; E_tnew = 2'd1;
    @(negedge clk); #1;
    check_stall_outs("reset_hazard", 1'b0);
    check("reset_md_busy", md_busy, 1'b0);
    tick(); tick();
    check("reset_stall_cycles", stall_cycles, 32'd0);
    idle_inputs();

    // Directed vector table.
    foreach (vecs[i]) begin
      D_rs = vecs[i].rs; D_tuse_rs = vecs[i].tuse_rs;
      D_rt = vecs[i].rt; D_tuse_rt = vecs[i].tuse_rt;
      D_is_md = vecs[i].is_md;
      E_dst = vecs[i].e_dst; E_tnew = vecs[i].e_tnew;
      M_dst = vecs[i].m_dst; M_tnew = vecs[i].m_tnew;
      #1;
      check_stall_outs($sformatf("vec%0d", i), vecs[i].exp_stall);
      tick();
    end
    idle_inputs();
    check("vec_stall_cycles", stall_cycles, 32'd3);

    // Multiply window: start at cycle 0 with md-class in D, stall 0..5.
    for (int i = 0; i <= 7; i++) begin
      D_is_md = 1'b1; E_md_start = (i == 0); E_md_is_div = 1'b0;
      #1;
      check_stall_outs($sformatf("mult_c%0d", i), i <= 5);
      check($sformatf("mult_busy_c%0d", i), md_busy, i <= 5);
      tick();
    end

    // Divide window: stall 0..10.
    for (int i = 0; i <= 12; i++) begin
      D_is_md = 1'b1; E_md_start = (i == 0); E_md_is_div = 1'b1;
      #1;
      check_stall_outs($sformatf("div_c%0d", i), i <= 10);
      tick();
    end
    check("md_stall_cycles", stall_cycles, 32'd3 + 32'd6 + 32'd11);

    // Reset three cycles into a divide window aborts it.
    for (int i = 0; i <= 4; i++) begin
      D_is_md = 1'b1; E_md_start = (i == 0); E_md_is_div = 1'b1;
      reset = (i == 3);
      #1;
      if (i < 3) check_stall_outs($sformatf("rstdiv_c%0d", i), 1'b1);
      else begin
        check_stall_outs($sformatf("rstdiv_c%0d", i), 1'b0);
        check($sformatf("rstdiv_busy_c%0d", i), md_busy, 1'b0);
      end
      tick();
      if (i == 3) check("rstdiv_stall_cycles", stall_cycles, 32'd0);
    end
    idle_inputs();

    // Randomized run against the model.
    for (int c = 0; c < 1000; c++) begin
      reset       = ($urandom_range(63) == 0);
      D_rs        = 5'($urandom_range(3));
      D_rt        = 5'($urandom_range(3));
      D_tuse_rs   = 2'($urandom_range(3));
      D_tuse_rt   = 2'($urandom_range(3));
      D_is_md     = ($urandom_range(3) == 0);
      E_dst       = 5'($urandom_range(3));
      M_dst       = 5'($urandom_range(3));
      E_tnew      = 2'($urandom_range(2));
      M_tnew      = 2'($urandom_range(2));
      E_md_start  = ($urandom_range(15) == 0);
      E_md_is_div = 1'($urandom_range(1));
      #1;
      check($sformatf("rand%0d.E_nop_n", c), E_nop_n, !model_stall());
      check($sformatf("rand%0d.pc_en", c),   pc_en,   !model_stall());
      check($sformatf("rand%0d.md_busy", c), md_busy, model_md_busy());
      tick();
      check($sformatf("rand%0d.stall_cycles", c), stall_cycles, 32'(m_stalls));
    end
    idle_inputs();

    // Saturation: preload near the top, then three stalled cycles.
    dut.stall_cycles_q = 32'hFFFF_FFFE;
    m_stalls = 64'hFFFF_FFFE;
    D_rs = 5'd5; D_tuse_rs = 2'd0; E_dst = 5'd5; E_tnew = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_stall_outs($sformatf("sat_c%0d", i), 1'b1);
      tick();
    end
    check("sat_stall_cycles", stall_cycles, 32'hFFFF_FFFF);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_controller.md
# stall_controller

Hazard and stall sequencer for the five-stage pipeline. Each cycle it compares the D-stage instruction's source registers and use-times against the destinations and new-times of the instructions in E and M, and tracks the multiply/divide unit's busy window. On a stall it freezes PC and the D pipeline register and forces the D→E NOP issuer to inject a bubble: its `E_nop_n` output drives the issuer's `enable` input, where 0 means issue NOP. It also keeps a saturating count of stalled cycles for performance debug.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles loaded for mult/multu.
- `DIV_CYCLES`, 10: busy cycles loaded for div/divu.
- `CNT_W`, 4: width of the busy counter; must hold `max(MULT_CYCLES, DIV_CYCLES)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `D_rs`, `D_rt` in 5: D-stage source register numbers.
- `D_tuse_rs`, `D_tuse_rt` in 2: cycles until the operand is needed. 0–2 are valid; `2'b11` means the operand is not used.
- `D_is_md` in 1: the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `E_dst`, `M_dst` in 5: destination register of the E and M instructions (0 = none).
- `E_tnew`, `M_tnew` in 2: cycles until that stage's result is forwardable, 0–2.
- `E_md_start` in 1: a mult/div instruction is in E this cycle.
- `E_md_is_div` in 1: qualifies `E_md_start`; 1 = div/divu.
- `pc_en` out 1: PC write enable.
- `D_reg_en` out 1: IF/ID register enable.
- `E_nop_n` out 1: to the NOP issuer `enable`; 0 = issue NOP into E.
- `md_busy` out 1: the multiply/divide unit is occupied.
- `stall_cycles` out 32: saturating count of stalled cycles.

## Operation
- Hazard rule for rs (rt identical with `D_rt`/`D_tuse_rt`):
  - `hz_rs = D_tuse_rs != 3 && D_rs != 0 && ((D_rs == E_dst && D_tuse_rs < E_tnew) || (D_rs == M_dst && D_tuse_rs < M_tnew))`.
  - Register 0 never hazards.
- Multiply/divide rule: `hz_md = D_is_md && md_busy`.
- `stall = !reset && (hz_rs || hz_rt || hz_md)`. Outputs follow from it:
  - `pc_en = D_reg_en = E_nop_n = !stall`.
  - All are combinational; there is no registered output path.
- Busy counter `cnt` (CNT_W bits):
  - On an edge with `E_md_start`, load `DIV_CYCLES` if `E_md_is_div`, else `MULT_CYCLES`.
  - Otherwise, if `cnt != 0`, decrement.
  - `md_busy = E_md_start || cnt != 0`.
  - A start while `cnt != 0` (not produced by a correct pipeline) reloads; it does not accumulate.
- `stall_cycles`: increments on each edge where `stall` = 1; holds at `32'hFFFF_FFFF`.
- Reset (synchronous, takes priority over all updates):
  - On the edge: `cnt` ← 0, `stall_cycles` ← 0.
  - While `reset` is high, `stall` is forced to 0, so `pc_en`, `D_reg_en` and `E_nop_n` are 1.
  - `md_busy` reflects `E_md_start` only.
  - Reset mid-busy aborts the window immediately.

## Timing
- Hazard outputs have zero latency: same cycle as the inputs.
- A multiply/divide start in cycle t loads `cnt` at the end of t. `md_busy` is high for cycles t through t+N, i.e. N+1 cycles, where N is the loaded value.
- An md-class instruction in D stalls through cycle t+N and advances in t+N+1.
- A stall persists until its hazard clears. The bubble advances E→M each stalled cycle, so Tnew-based stalls resolve naturally. This block has no timeout.
- Simultaneous register and md hazards produce one stall; `stall_cycles` counts one per cycle.

## Structure
- Shared package `pipeline_pkg`:
  - `TUSE_NONE = 2'b11`.
  - Tuse/Tnew width constant.
  - `MULT_CYCLES_DEF` / `DIV_CYCLES_DEF`.
  - md-class opcode/funct constants used by decode to form `D_is_md`.
- One sub-module, `md_busy_tracker`: holds `cnt` and produces `md_busy`. Hazard comparison and the performance counter stay in the top level.

## Test plan
- `D_rs=5, D_tuse_rs=0, E_dst=5, E_tnew=1`, no M match → `stall=1`, `pc_en=D_reg_en=E_nop_n=0`. The same with `D_rs=0` → no stall.
- `D_rt=7, D_tuse_rt=1, M_dst=7, M_tnew=1` → no stall (1<1 false). `M_tnew=2` → stall. `D_tuse_rt=3` → no stall.
- Pulse `E_md_start` with `E_md_is_div=0` at cycle 10, holding `D_is_md=1` → stall in cycles 10–15 and release at 16. With `E_md_is_div=1` → stall in cycles 10–20.
- Assert `reset` at cycle 13 of a div window → `pc_en=1` during reset and `cnt=0` after the edge. With `reset` low at cycle 14 and `E_md_start=0`, `md_busy=0`.
- Force `stall_cycles` near saturation (preload via 2^32 stalls in a fast model, or a hierarchical deposit of `32'hFFFF_FFFE`) plus 3 stalled cycles → reads `32'hFFFF_FFFF`.
- Random stall/no-stall sequence over 1000 cycles → `stall_cycles` equals the bench's count of `stall` cycles; `E_nop_n == !stall` at every cycle.
